// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: one bit per clock, LSB first, with a
// single carry/borrow flip-flop. Operands are latched on accept so the
// inputs are free to change while the operation runs. result, bout and
// ovf only change on the edge that completes an operation.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             ovf
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_full;
  logic             w_ovf;

  // A new request is taken whenever no operation is in flight, including
  // the DONE cycle, which gives back-to-back operation.
  assign w_accept = start && (r_state != S_RUN);

  // Bit-slice datapath for the current bit plus the completed-word view
  // used on the final edge (partial word with the current bit merged in).
  always_comb begin
    w_ai      = r_a[r_cnt];
    w_bi      = r_b[r_cnt];
    w_d       = w_ai ^ w_bi ^ r_br;
    if (r_mode) begin
      w_br_next = (w_ai & w_bi) | (w_ai & r_br) | (w_bi & r_br);
    end else begin
      w_br_next = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);
    end
    w_full        = r_shift;
    w_full[r_cnt] = w_d;
    if (r_mode) begin
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
    end else begin
      w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  // Control FSM and datapath registers; outputs are all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_RUN;
        r_a     <= a;
        r_b     <= b;
        r_mode  <= mode;
        r_br    <= cin;
        r_cnt   <= '0;
        r_shift <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_shift <= w_full;
        r_br    <= w_br_next;
        if (r_cnt == LAST_BIT) begin
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= w_full;
          r_bout   <= w_br_next;
          r_ovf    <= w_ovf;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign bout   = r_bout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=1 and WIDTH=8. Stimulus
// pushes the expected outcome (from plain integer arithmetic) and its
// timing; per-width monitors compare busy/done every cycle and the
// result fields on each done pulse.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, mode8, cin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, result8;
  logic       start1, mode1, cin1, busy1, done1, bout1, ovf1;
  logic [0:0] a1, b1, result1;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .result(result8), .bout(bout8),
    .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .result(result1), .bout(bout1),
    .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] res;
    logic       bo;
    logic       ov;
    int         acc;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   cycle  = 0;
  int   errors = 0;
  int   checks = 0;
  logic eb8, ed8, eb1, ed1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference: integer arithmetic on the operand values, bout from the
  // range of the unsigned result, ovf from the range of the signed result.
  function automatic logic [65:0] ref_op(input int w, input logic md,
                                         input longint av, input longint bv,
                                         input logic c);
    longint mask, half, ua, ub, sa, sb, full, s, ci;
    logic   bo, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = av & mask;
    ub   = bv & mask;
    ci   = c ? 1 : 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (md) begin
      full = ua + ub + ci;
      s    = sa + sb + ci;
      bo   = (full > mask);
    end else begin
      full = ua - ub - ci;
      s    = sa - sb - ci;
      bo   = (full < 0);
    end
    ov = (s > half - 1) || (s < -half);
    return {ov, bo, 64'(full & mask)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an 8-bit op; caller ensures the DUT is idle or in its DONE cycle.
  task automatic issue8(input logic md, input logic [7:0] av, input logic [7:0] bv,
                        input logic c);
    logic [65:0] r;
    exp_t        e;
    r = ref_op(8, md, longint'(av), longint'(bv), c);
    mode8 = md; a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
    e.res = r[7:0]; e.bo = r[64]; e.ov = r[65];
    e.acc = cycle + 1; e.due = cycle + 1 + 8;
    q8.push_back(e);
    step();
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic md, input logic av, input logic bv, input logic c);
    logic [65:0] r;
    exp_t        e;
    r = ref_op(1, md, longint'(av), longint'(bv), c);
    mode1 = md; a1 = av; b1 = bv; cin1 = c; start1 = 1'b1;
    e.res = r[7:0]; e.bo = r[64]; e.ov = r[65];
    e.acc = cycle + 1; e.due = cycle + 1 + 1;
    q1.push_back(e);
    step();
    start1 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 200) begin step(); n++; end
    if (!done8) begin
      checks++; errors++;
      $display("FAIL done8_timeout: got no done, expected done within 200 cycles");
    end
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 200) begin step(); n++; end
    if (!done1) begin
      checks++; errors++;
      $display("FAIL done1_timeout: got no done, expected done within 200 cycles");
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      eb8 = (q8.size() > 0) && (cycle >= q8[0].acc) && (cycle < q8[0].due);
      ed8 = (q8.size() > 0) && (cycle == q8[0].due);
      chk("busy8", longint'(busy8), longint'(eb8));
      chk("done8", longint'(done8), longint'(ed8));
      if (ed8 && done8) begin
        chk("result8", longint'(result8), longint'(q8[0].res));
        chk("bout8", longint'(bout8), longint'(q8[0].bo));
        chk("ovf8", longint'(ovf8), longint'(q8[0].ov));
        $display("W8 op done cycle %0d: result=%02h bout=%0b ovf=%0b (exp %02h %0b %0b)",
                 cycle, result8, bout8, ovf8, q8[0].res, q8[0].bo, q8[0].ov);
      end
      if ((q8.size() > 0) && (cycle >= q8[0].due)) void'(q8.pop_front());
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      eb1 = (q1.size() > 0) && (cycle >= q1[0].acc) && (cycle < q1[0].due);
      ed1 = (q1.size() > 0) && (cycle == q1[0].due);
      chk("busy1", longint'(busy1), longint'(eb1));
      chk("done1", longint'(done1), longint'(ed1));
      if (ed1 && done1) begin
        chk("result1", longint'(result1), longint'(q1[0].res[0]));
        chk("bout1", longint'(bout1), longint'(q1[0].bo));
        chk("ovf1", longint'(ovf1), longint'(q1[0].ov));
        $display("W1 op done cycle %0d: result=%0b bout=%0b ovf=%0b (exp %0b %0b %0b)",
                 cycle, result1, bout1, ovf1, q1[0].res[0], q1[0].bo, q1[0].ov);
      end
      if ((q1.size() > 0) && (cycle >= q1[0].due)) void'(q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; mode1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) step();
    chk("rst_busy8", longint'(busy8), 0);
    chk("rst_done8", longint'(done8), 0);
    chk("rst_result8", longint'(result8), 0);
    chk("rst_bout8", longint'(bout8), 0);
    chk("rst_ovf8", longint'(ovf8), 0);
    chk("rst_result1", longint'(result1), 0);
    rst = 1'b0;
    step();

    // WIDTH=1: every (mode,a,b,cin) combination, done one cycle after accept.
    for (int i = 0; i < 16; i++) begin
      issue1(i[3], i[2], i[1], i[0]);
      wait_done1();
      step();
    end

    // WIDTH=8 directed subtract and add cases.
    issue8(1'b0, 8'h05, 8'h03, 1'b0); wait_done8(); step();
    issue8(1'b0, 8'h03, 8'h05, 1'b0); wait_done8(); step();
    issue8(1'b0, 8'h80, 8'h01, 1'b0); wait_done8(); step();
    issue8(1'b1, 8'hFF, 8'h01, 1'b0); wait_done8(); step();
    issue8(1'b1, 8'h7F, 8'h01, 1'b0); wait_done8(); step();
    issue8(1'b1, 8'h10, 8'h20, 1'b1); wait_done8(); step();

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    issue8(1'b0, 8'h05, 8'h03, 1'b0);
    repeat (3) step();
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
    step();
    start8 = 1'b0;
    wait_done8();
    issue8(1'b0, 8'h09, 8'h01, 1'b0);
    wait_done8();
    step();

    // Operands scrambled every cycle during RUN.
    issue8(1'b0, 8'h05, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      mode8 = 1'($urandom); cin8 = 1'($urandom);
      step();
    end
    wait_done8();
    step();

    // Reset mid-operation aborts with no done pulse.
    issue8(1'b0, 8'h77, 8'h12, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    q8.delete();
    rst = 1'b0;
    chk("abort_busy8", longint'(busy8), 0);
    chk("abort_done8", longint'(done8), 0);
    chk("abort_result8", longint'(result8), 0);
    chk("abort_bout8", longint'(bout8), 0);
    chk("abort_ovf8", longint'(ovf8), 0);
    repeat (12) step();
    issue8(1'b0, 8'h40, 8'h41, 1'b0); wait_done8(); step();

    // Random operations with random gaps, including back-to-back.
    for (int i = 0; i < 40; i++) begin
      issue8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8();
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (12) step();
    chk("q8_drained", longint'(q8.size()), 0);
    chk("q1_drained", longint'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial add/subtract unit; generalises the single-bit full subtractor to WIDTH-bit operands.
- Uses one borrow/carry flip-flop and processes one bit per clock, LSB first.
- Start/done handshake; serves as a low-area arithmetic engine where multi-cycle latency is acceptable.
- Chainable via cin/bout.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1 to 64.

Ports:
clk     input   1      rising-edge clock
rst     input   1      synchronous active-high reset
start   input   1      request; sampled only when not busy
mode    input   1      0 = subtract (a - b - cin), 1 = add (a + b + cin); latched at accept
a       input   WIDTH  minuend/addend; latched at accept
b       input   WIDTH  subtrahend/addend; latched at accept
cin     input   1      initial borrow (sub) or carry (add); latched at accept
busy    output  1      operation in progress
done    output  1      one-cycle pulse, result valid
result  output  WIDTH  difference/sum; holds last completed value
bout    output  1      final borrow (sub) or carry-out (add); holds
ovf     output  1      signed two's-complement overflow; holds

Behaviour:
- Reset (rst=1 at a rising edge):
  - state -> IDLE.
  - busy=0, done=0, result=0, bout=0, ovf=0.
  - Internal operand, shift and borrow registers cleared.
  - Overrides everything, including mid-operation; the aborted operation produces no done.
- States:
  - IDLE: wait for start.
  - RUN: bit counter 0..WIDTH-1.
  - DONE: one cycle.
- Accept:
  - start=1 at edge k while state is IDLE or DONE -> latch a, b, mode, cin; bit counter=0; br=cin; state=RUN.
  - busy=1 from edge k onward.
  - start while RUN is ignored; inputs are not re-sampled.
- RUN, one bit i per edge, using latched operands:
  - sub: d = a[i]^b[i]^br; br' = (~a[i]&b[i]) | (~a[i]&br) | (b[i]&br)
  - add: d = a[i]^b[i]^br; br' = (a[i]&b[i]) | (a[i]&br) | (b[i]&br)
  - d is shifted into the internal result register at position i.
  - Counter increments; after bit WIDTH-1 the state goes to DONE.
- Latency: start accepted at edge k -> bits at edges k+1..k+WIDTH -> done=1 and busy=0 after edge k+WIDTH, for exactly one cycle.
- Output update:
  - result, bout and ovf update only on the edge entering DONE.
  - They are stable between completions; an intermediate partial result is never visible.
- ovf, with sign bits a_s = a[WIDTH-1], b_s = b[WIDTH-1], r_s = result[WIDTH-1]:
  - sub: (a_s != b_s) & (r_s != a_s)
  - add: (a_s == b_s) & (r_s != a_s)
- DONE -> IDLE next edge unless start=1, which gives back-to-back accept with done still pulsing that cycle. Throughput is therefore one operation per WIDTH+1 cycles.
- WIDTH=1 degenerates to a registered full subtractor/adder:
  - done 1 cycle after accept.
  - ovf per formula with the single bit as sign.
- Arithmetic is modulo 2^WIDTH; bout is the carry/borrow out of the MSB; no saturation.

Test Plan:
1. WIDTH=1, sub mode, all 8 (a,b,cin) combinations -> result = a^b^cin and bout = (~a&b)|(~a&cin)|(b&cin) for each; done exactly 1 cycle after each accept.
2. WIDTH=8, sub, cin=0:
   - 0x05-0x03 -> result 0x02, bout 0, ovf 0; done 8 cycles after accept edge, busy high for those 8.
   - 0x03-0x05 -> result 0xFE, bout 1, ovf 0.
   - 0x80-0x01 -> result 0x7F, bout 0, ovf 1.
3. WIDTH=8, add:
   - 0xFF+0x01, cin=0 -> result 0x00, bout 1, ovf 0.
   - 0x7F+0x01 -> result 0x80, bout 0, ovf 1.
   - 0x10+0x20, cin=1 -> result 0x31.
4. WIDTH=8, start 0x05-0x03, then start=1 with a=0xAA, b=0x11 at bit 3 -> ignored; single done pulse, result 0x02. A start held high during the DONE cycle with 0x09-0x01 -> accepted back-to-back, result 0x08 eight cycles later.
5. Operands changed every cycle during RUN -> result still reflects the latched values (0x05-0x03 = 0x02).
6. Prior result 0x02, new op started, rst=1 at bit 4 -> next cycle busy=0, done=0, result=0x00, bout=0, ovf=0; no done pulse follows. A fresh 0x40-0x41 then yields result 0xFF, bout 1, ovf 0.
